// File: rtl/program_memory_loader.sv
// program_memory_loader: run-time loadable instruction memory with a registered fetch port
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   fetch_en, fetch_addr      fetch request (honoured only while idle)
//   instr_out, instr_valid    registered fetch result, one cycle after the request
//   load_start                begins a new program download (idle only)
//   load_byte/valid/last      byte stream, MSB-first within each instruction word
//   load_ready, load_busy     loader is accepting bytes
//   load_done                 one-cycle pulse when a download finishes
//   load_err                  sticky: last download ended on a partial word
//   load_count                words written by the current/last download
module program_memory_loader #(
    parameter int ADDR_WIDTH  = 6,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_en,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    input  logic                   load_start,
    input  logic [7:0]             load_byte,
    input  logic                   load_valid,
    input  logic                   load_last,
    output logic                   load_ready,
    output logic                   load_busy,
    output logic                   load_done,
    output logic                   load_err,
    output logic [ADDR_WIDTH:0]    load_count
);
    localparam int SIZE = 2 ** ADDR_WIDTH;
    localparam int BPI  = INSTR_WIDTH / 8;
    localparam int IDXW = BPI > 1 ? $clog2(BPI) : 1;
    localparam int CW   = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                 state, state_next;
    logic [INSTR_WIDTH-1:0] mem [SIZE] = '{default: '0};
    logic [INSTR_WIDTH-1:0] asm_word, word;
    logic [IDXW-1:0]        idx;
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic                   accept, word_end, word_wr, finish, fetch_go, begin_load;

    assign accept     = load_valid && state == LOAD;
    assign word_end   = idx == IDXW'(BPI - 1);
    assign word_wr    = accept && word_end;
    // The word written at the top address fills the memory, so the load ends there.
    assign finish     = accept && (load_last || (word_end && &wr_ptr));
    assign fetch_go   = fetch_en && state == IDLE;
    assign begin_load = load_start && state == IDLE;
    // Older bytes shift towards the MSB; bytes beyond one word fall off the top.
    assign word       = (asm_word << 8) | INSTR_WIDTH'(load_byte);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = load_start ? LOAD : IDLE;
            LOAD:    state_next = finish ? DONE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_ready = state == LOAD;
        load_busy  = state == LOAD;
        load_done  = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_out   <= '0;
            instr_valid <= 1'b0;
            asm_word    <= '0;
            idx         <= '0;
            wr_ptr      <= '0;
            load_count  <= '0;
            load_err    <= 1'b0;
        end else begin
            instr_valid <= fetch_go;
            if (fetch_go) instr_out <= mem[fetch_addr];
            if (begin_load) begin
                asm_word   <= '0;
                idx        <= '0;
                wr_ptr     <= '0;
                load_count <= '0;
                load_err   <= 1'b0;
            end else if (accept) begin
                asm_word <= word;
                idx      <= word_end ? '0 : idx + IDXW'(1);
                if (word_end) begin
                    wr_ptr     <= wr_ptr + ADDR_WIDTH'(1);
                    load_count <= load_count + CW'(1);
                end
                if (load_last && !word_end) load_err <= 1'b1;
            end
        end
    end

    // Memory contents survive reset so an aborted load keeps what it already wrote.
    always_ff @(posedge clk) begin
        if (word_wr) mem[wr_ptr] <= word;
    end
endmodule

// File: tb/tb_program_memory_loader.sv
// tb_program_memory_loader: scoreboard bench for program_memory_loader (default and 4-word instances)
module tb_program_memory_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, fetch_en_a = 1'b0, load_start_a = 1'b0, load_valid_a = 1'b0, load_last_a = 1'b0;
    logic [5:0]  fetch_addr_a = '0;
    logic [7:0]  load_byte_a = '0;
    logic [15:0] instr_out_a;
    logic        instr_valid_a, load_ready_a, load_busy_a, load_done_a, load_err_a;
    logic [6:0]  load_count_a;

    logic        rst_b = 1'b1, fetch_en_b = 1'b0, load_start_b = 1'b0, load_valid_b = 1'b0, load_last_b = 1'b0;
    logic [1:0]  fetch_addr_b = '0;
    logic [7:0]  load_byte_b = '0;
    logic [15:0] instr_out_b;
    logic        instr_valid_b, load_ready_b, load_busy_b, load_done_b, load_err_b;
    logic [2:0]  load_count_b;

    program_memory_loader #(.ADDR_WIDTH(6), .INSTR_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst_a), .fetch_en(fetch_en_a), .fetch_addr(fetch_addr_a),
        .instr_out(instr_out_a), .instr_valid(instr_valid_a), .load_start(load_start_a),
        .load_byte(load_byte_a), .load_valid(load_valid_a), .load_last(load_last_a),
        .load_ready(load_ready_a), .load_busy(load_busy_a), .load_done(load_done_a),
        .load_err(load_err_a), .load_count(load_count_a)
    );

    program_memory_loader #(.ADDR_WIDTH(2), .INSTR_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst_b), .fetch_en(fetch_en_b), .fetch_addr(fetch_addr_b),
        .instr_out(instr_out_b), .instr_valid(instr_valid_b), .load_start(load_start_b),
        .load_byte(load_byte_b), .load_valid(load_valid_b), .load_last(load_last_b),
        .load_ready(load_ready_b), .load_busy(load_busy_b), .load_done(load_done_b),
        .load_err(load_err_b), .load_count(load_count_b)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] instr_q_a[$], instr_q_b[$];
    int          done_q_a[$], done_q_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spurious(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got unexpected output %0h expected none", name, act);
    endtask

    // Monitors: pop the expected response whenever a DUT presents one.
    always @(negedge clk) begin
        if (instr_valid_a === 1'b1) begin
            if (instr_q_a.size() == 0) spurious("a_fetch", 64'(instr_out_a));
            else check("a_fetch", 64'(instr_out_a), 64'(instr_q_a.pop_front()));
        end
        if (load_done_a === 1'b1) begin
            if (done_q_a.size() == 0) spurious("a_done", 64'({load_count_a, load_err_a}));
            else check("a_done_count_err", 64'({load_count_a, load_err_a}), 64'(done_q_a.pop_front()));
        end
        if (instr_valid_b === 1'b1) begin
            if (instr_q_b.size() == 0) spurious("b_fetch", 64'(instr_out_b));
            else check("b_fetch", 64'(instr_out_b), 64'(instr_q_b.pop_front()));
        end
        if (load_done_b === 1'b1) begin
            if (done_q_b.size() == 0) spurious("b_done", 64'({load_count_b, load_err_b}));
            else check("b_done_count_err", 64'({load_count_b, load_err_b}), 64'(done_q_b.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b, input logic last);
        load_valid_a = 1'b1; load_byte_a = b; load_last_a = last;
        step();
        load_valid_a = 1'b0; load_last_a = 1'b0;
    endtask

    task automatic start_a();
        load_start_a = 1'b1;
        step();
        load_start_a = 1'b0;
    endtask

    task automatic fetch_a(input logic [5:0] addr, input logic [15:0] exp);
        instr_q_a.push_back(exp);
        fetch_en_a = 1'b1; fetch_addr_a = addr;
        step();
        fetch_en_a = 1'b0;
        check("a_fetch_latency", 64'(instr_valid_a), 64'd1);
    endtask

    task automatic send_b(input logic [7:0] b);
        load_valid_b = 1'b1; load_byte_b = b;
        step();
        load_valid_b = 1'b0;
    endtask

    task automatic fetch_b(input logic [1:0] addr, input logic [15:0] exp);
        instr_q_b.push_back(exp);
        fetch_en_b = 1'b1; fetch_addr_b = addr;
        step();
        fetch_en_b = 1'b0;
        check("b_fetch_latency", 64'(instr_valid_b), 64'd1);
    endtask

    initial begin
        step();
        step();
        check("a_reset_outputs", 64'({instr_out_a, instr_valid_a, load_ready_a, load_busy_a, load_done_a, load_err_a, load_count_a}), 64'd0);
        check("b_reset_outputs", 64'({instr_out_b, instr_valid_b, load_ready_b, load_busy_b, load_done_b, load_err_b, load_count_b}), 64'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        step();

        // Two full words.
        done_q_a.push_back(2 * 2 + 0);
        start_a();
        check("a_ready_busy_in_load", 64'({load_ready_a, load_busy_a}), 64'b11);
        send_a(8'hB2, 1'b0);
        send_a(8'h03, 1'b0);
        send_a(8'hB3, 1'b0);
        send_a(8'h05, 1'b1);
        check("a_ready_busy_in_done", 64'({load_ready_a, load_busy_a}), 64'b00);
        step();
        fetch_a(6'd0, 16'hB203);
        fetch_a(6'd1, 16'hB305);
        step();
        check("a_valid_drops", 64'(instr_valid_a), 64'd0);
        check("a_instr_holds", 64'(instr_out_a), 64'hB305);

        // Partial trailing word: only the first word is written, error flagged.
        done_q_a.push_back(1 * 2 + 1);
        start_a();
        send_a(8'h11, 1'b0);
        send_a(8'h22, 1'b0);
        send_a(8'h33, 1'b1);
        step();
        check("a_err_sticky", 64'(load_err_a), 64'd1);
        fetch_a(6'd0, 16'h1122);
        fetch_a(6'd1, 16'hB305);

        // New load clears the error; fetches and a second start are ignored mid-load.
        done_q_a.push_back(2 * 2 + 0);
        start_a();
        check("a_err_cleared", 64'({load_err_a, load_count_a}), 64'd0);
        fetch_en_a = 1'b1; fetch_addr_a = 6'd1;
        send_a(8'h01, 1'b0);
        send_a(8'h02, 1'b0);
        load_start_a = 1'b1;
        step();
        load_start_a = 1'b0;
        check("a_count_after_restart_pulse", 64'(load_count_a), 64'd1);
        send_a(8'h03, 1'b0);
        send_a(8'h04, 1'b1);
        fetch_en_a = 1'b0;
        step();
        fetch_a(6'd0, 16'h0102);
        fetch_a(6'd1, 16'h0304);

        // Reset mid-load: outputs clear, already-written words survive.
        start_a();
        send_a(8'hAA, 1'b0);
        send_a(8'hBB, 1'b0);
        send_a(8'hCC, 1'b0);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("a_midload_reset_outputs", 64'({instr_out_a, instr_valid_a, load_ready_a, load_busy_a, load_done_a, load_err_a, load_count_a}), 64'd0);
        fetch_a(6'd0, 16'hAABB);
        fetch_a(6'd1, 16'h0304);

        // Four-word memory fills after 8 bytes with no load_last; extra bytes dropped.
        done_q_b.push_back(4 * 2 + 0);
        load_start_b = 1'b1;
        step();
        load_start_b = 1'b0;
        for (int i = 1; i <= 8; i++) send_b(8'(i));
        check("b_ready_after_full", 64'(load_ready_b), 64'd0);
        send_b(8'h09);
        check("b_ready_idle", 64'(load_ready_b), 64'd0);
        send_b(8'h0A);
        check("b_count_after_drop", 64'({load_count_b, load_err_b}), 64'd8);
        fetch_b(2'd0, 16'h0102);
        fetch_b(2'd1, 16'h0304);
        fetch_b(2'd2, 16'h0506);
        fetch_b(2'd3, 16'h0708);

        step();
        step();
        check("a_queues_drained", 64'(instr_q_a.size() + done_q_a.size()), 64'd0);
        check("b_queues_drained", 64'(instr_q_b.size() + done_q_b.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
